hazard_ctrl: RTL and testbench

Pipeline hazard controller for the IF/ID instruction register and the PC. Each cycle it decides whether IF/ID advances, holds, or is flushed, and whether a bubble enters ID/EX. It handles load-use hazards with a configurable stall length, taken-branch flushes, and data-memory wait freezes. It drives the instruction register's clear input, the enables of the PC and the instruction register, and the ID/EX bubble select.

---
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the IF/ID instruction register
// and the PC. Each cycle it decides whether IF/ID advances, holds or is
// flushed, and whether a bubble is injected into ID/EX.
//
// Parameters:
//   REG_IDX_W  register index width
//   LOAD_LAT   bubbles inserted per load-use hazard (legal range 1..4)
//   CNT_W      performance counter width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source indices of the instruction in ID
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads rs1/rs2
//   ex_rd, ex_is_load        destination and load flag of the instruction in EX
//   ex_branch_taken          EX resolved a taken branch/jump
//   mem_busy                 data memory not ready, whole pipe freezes
//   pc_en, ir_en             PC / IF-ID load enables
//   ir_flush                 IF/ID clear
//   idex_bubble              inject NOP into ID/EX
//   state                    RUN=0, LSTALL=1, FLUSH=2, MWAIT=3
//   stall_cycles, flush_count, wait_cycles   performance counters
//
// Build option: define HAZ_PERF_CNT_EN to build the saturating performance
// counters; without it the three counter ports are tied to zero.

module hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 ir_en,
  output logic                 ir_flush,
  output logic                 idex_bubble,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count,
  output logic [CNT_W-1:0]     wait_cycles
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LSTALL = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_MWAIT  = 2'd3;

  // The hazard cycle itself is the first bubble, so LSTALL only has to
  // cover the remaining LOAD_LAT-1 cycles; the counter ends at zero.
  localparam logic [1:0] CNT_INIT = 2'((LOAD_LAT >= 2) ? (LOAD_LAT - 2) : 0);

  logic [1:0] r_state;
  logic [1:0] r_cnt;
  logic [1:0] w_state_nxt;
  logic [1:0] w_cnt_nxt;
  logic       w_lu;
  logic       w_pc_en;
  logic       w_ir_en;
  logic       w_ir_flush;
  logic       w_idex_bubble;

  assign w_lu = ex_is_load && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Output decode: reset > freeze > branch > state-specific behaviour.
  always_comb begin
    w_pc_en       = 1'b1;
    w_ir_en       = 1'b1;
    w_ir_flush    = 1'b0;
    w_idex_bubble = 1'b0;
    if (rst) begin
      // Clears IF/ID on the same edge that resets the controller.
      w_pc_en       = 1'b0;
      w_ir_en       = 1'b0;
      w_ir_flush    = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (mem_busy) begin
      w_pc_en = 1'b0;
      w_ir_en = 1'b0;
    end else if (ex_branch_taken) begin
      w_ir_en       = 1'b0;
      w_ir_flush    = 1'b1;
      w_idex_bubble = 1'b1;
    end else begin
      case (r_state)
        S_RUN, S_MWAIT: begin
          if (w_lu) begin
            w_pc_en       = 1'b0;
            w_ir_en       = 1'b0;
            w_idex_bubble = 1'b1;
          end
        end
        S_LSTALL: begin
          w_pc_en       = 1'b0;
          w_ir_en       = 1'b0;
          w_idex_bubble = 1'b1;
        end
        default: begin
          // FLUSH: ID holds the cleared NOP, so a hazard match is spurious.
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (mem_busy) begin
      // A load-use stall in progress is simply paused by the freeze.
      if (r_state != S_LSTALL) w_state_nxt = S_MWAIT;
    end else if (ex_branch_taken) begin
      w_state_nxt = S_FLUSH;
      w_cnt_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_RUN, S_MWAIT: begin
          w_state_nxt = S_RUN;
          if (w_lu && (LOAD_LAT > 1)) begin
            w_state_nxt = S_LSTALL;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        S_LSTALL: begin
          if (r_cnt == 2'd0) w_state_nxt = S_RUN;
          else               w_cnt_nxt   = r_cnt - 2'd1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // State register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_en       = w_pc_en;
  assign ir_en       = w_ir_en;
  assign ir_flush    = w_ir_flush;
  assign idex_bubble = w_idex_bubble;
  assign state       = r_state;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_wait_cycles;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Performance counter boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wait_cycles  <= '0;
    end else begin
      if (w_idex_bubble && !w_ir_flush) r_stall_cycles <= sat_inc(r_stall_cycles);
      if (w_ir_flush)                   r_flush_count  <= sat_inc(r_flush_count);
      if (mem_busy)                     r_wait_cycles  <= sat_inc(r_wait_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign wait_cycles  = r_wait_cycles;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign wait_cycles  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Three instances (LOAD_LAT 1/2/3) share
// one stimulus; the LOAD_LAT=1 instance uses 4-bit counters for saturation.
module tb_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, mem_busy;

  logic        pc1, ir1, fl1, bb1;
  logic [1:0]  st1;
  logic [3:0]  sc1, fc1, wc1;
  logic        pc2, ir2, fl2, bb2;
  logic [1:0]  st2;
  logic [15:0] sc2, fc2, wc2;
  logic        pc3, ir3, fl3, bb3;
  logic [1:0]  st3;
  logic [15:0] sc3, fc3, wc3;

  int total = 0;
  int bad   = 0;
  int lo1, lo2, lo3;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_IDX_W(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc1), .ir_en(ir1), .ir_flush(fl1), .idex_bubble(bb1), .state(st1),
    .stall_cycles(sc1), .flush_count(fc1), .wait_cycles(wc1));

  hazard_ctrl #(.REG_IDX_W(5), .LOAD_LAT(2), .CNT_W(16)) u_lat2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc2), .ir_en(ir2), .ir_flush(fl2), .idex_bubble(bb2), .state(st2),
    .stall_cycles(sc2), .flush_count(fc2), .wait_cycles(wc2));

  hazard_ctrl #(.REG_IDX_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc3), .ir_en(ir3), .ir_flush(fl3), .idex_bubble(bb3), .state(st3),
    .stall_cycles(sc3), .flush_count(fc3), .wait_cycles(wc3));

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu();
    set_idle();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  // Inputs change 1ns after the active edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      chk_val("rst_pc_en",    32'(pc3), 0);
      chk_val("rst_ir_en",    32'(ir3), 0);
      chk_val("rst_ir_flush", 32'(fl3), 1);
      chk_val("rst_bubble",   32'(bb3), 1);
    end
    rst = 1'b0;
    #1;
    chk_val("post_rst_state", 32'(st3), 0);
    chk_val("post_rst_pc_en", 32'(pc3), 1);
    chk_val("post_rst_ir_en", 32'(ir3), 1);
    chk_val("post_rst_flush", 32'(fl3), 0);
    chk_val("post_rst_stall", 32'(sc3), 0);
    chk_val("post_rst_fcnt",  32'(fc3), 0);
    chk_val("post_rst_wait",  32'(wc3), 0);

    // Load-use stall length per LOAD_LAT; EX holds a bubble after cycle 0.
    lo1 = 0; lo2 = 0; lo3 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) set_lu(); else set_idle();
      #1;
      if (k == 0) begin
        chk_val("lu_bubble_l1", 32'(bb1), 1);
        chk_val("lu_bubble_l3", 32'(bb3), 1);
        chk_val("lu_irflush_l3", 32'(fl3), 0);
      end
      if (k == 1) begin
        chk_val("lu_state_l1", 32'(st1), 0);
        chk_val("lu_state_l2", 32'(st2), 1);
        chk_val("lu_state_l3", 32'(st3), 1);
      end
      if (!pc1) lo1++;
      if (!pc2) lo2++;
      if (!pc3) lo3++;
    end
    chk_val("lu_len_l1", 32'(lo1), 1);
    chk_val("lu_len_l2", 32'(lo2), 2);
    chk_val("lu_len_l3", 32'(lo3), 3);
    chk_val("lu_end_state_l3", 32'(st3), 0);

    // Cases that must not stall.
    tick();
    set_idle(); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    chk_val("rd0_pc_en",  32'(pc3), 1);
    chk_val("rd0_bubble", 32'(bb3), 0);
    tick();
    set_idle(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
    #1;
    chk_val("nouse_pc_en", 32'(pc3), 1);
    tick();
    set_idle(); ex_is_load = 1'b0; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1;
    chk_val("noload_pc_en", 32'(pc3), 1);
    tick();
    set_idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1;
    chk_val("rs1_pc_en",  32'(pc3), 0);
    chk_val("rs1_bubble", 32'(bb3), 1);
    repeat (4) begin tick(); set_idle(); end

    // Branch in the second stall cycle of a LOAD_LAT=3 stall.
    tick(); set_lu(); #1;
    chk_val("bls_c1_pc_en", 32'(pc3), 0);
    tick(); set_idle(); ex_branch_taken = 1'b1; #1;
    chk_val("bls_flush",  32'(fl3), 1);
    chk_val("bls_pc_en",  32'(pc3), 1);
    chk_val("bls_ir_en",  32'(ir3), 0);
    chk_val("bls_bubble", 32'(bb3), 1);
    tick(); set_lu(); #1;
    chk_val("fl_state",  32'(st3), 2);
    chk_val("fl_pc_en",  32'(pc3), 1);
    chk_val("fl_ir_en",  32'(ir3), 1);
    chk_val("fl_bubble", 32'(bb3), 0);
    chk_val("fl_flush",  32'(fl3), 0);
    tick(); set_idle(); #1;
    chk_val("fl_done_state", 32'(st3), 0);
    chk_val("fl_done_pc_en", 32'(pc3), 1);

    // Reset in the middle of a load-use stall.
    tick(); set_lu(); #1;
    tick(); set_idle(); rst = 1'b1; #1;
    chk_val("rstls_pc_en", 32'(pc3), 0);
    chk_val("rstls_flush", 32'(fl3), 1);
    tick(); rst = 1'b0; #1;
    chk_val("rstls_state",  32'(st3), 0);
    chk_val("rstls_pc_en",  32'(pc3), 1);
    chk_val("rstls_bubble", 32'(bb3), 0);

    // Freeze together with a branch: freeze wins, branch follows.
    for (int k = 0; k < 4; k++) begin
      tick(); set_idle(); mem_busy = 1'b1; ex_branch_taken = 1'b1; #1;
      chk_val("mw_pc_en", 32'(pc3), 0);
      chk_val("mw_ir_en", 32'(ir3), 0);
      chk_val("mw_flush", 32'(fl3), 0);
      chk_val("mw_bubble", 32'(bb3), 0);
      if (k > 0) chk_val("mw_state", 32'(st3), 3);
    end
    tick(); mem_busy = 1'b0; ex_branch_taken = 1'b1; #1;
    chk_val("mw_br_state", 32'(st3), 3);
    chk_val("mw_br_flush", 32'(fl3), 1);
    chk_val("mw_br_pc_en", 32'(pc3), 1);
    chk_val("mw_br_ir_en", 32'(ir3), 0);
    tick(); set_idle(); #1;
    chk_val("mw_fl_state", 32'(st3), 2);
    chk_val("mw_wait_cnt", 32'(wc3), 32'(4 * PERF));
    chk_val("mw_flush_cnt", 32'(fc3), 32'(PERF));
    chk_val("mw_stall_cnt", 32'(sc3), 0);
    tick(); #1;
    chk_val("mw_end_state", 32'(st3), 0);

    // Twenty isolated load-use hazards; 4-bit counter must saturate.
    for (int h = 0; h < 20; h++) begin
      tick(); set_lu();
      tick(); set_idle();
      if (h == 9) begin
        #1;
        chk_val("sat_mid_l1", 32'(sc1), 32'(10 * PERF));
      end
    end
    tick(); #1;
    chk_val("sat_end_l1", 32'(sc1), 32'(15 * PERF));
    chk_val("stall_l2",   32'(sc2), 32'(40 * PERF));
    chk_val("stall_l3",   32'(sc3), 32'(30 * PERF));
    chk_val("fcnt_l1",    32'(fc1), 32'(PERF));

    // Reset in the middle of a memory wait.
    tick(); set_idle(); mem_busy = 1'b1; #1;
    tick(); #1;
    chk_val("rstmw_state", 32'(st3), 3);
    tick(); mem_busy = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk_val("rstmw_state_after", 32'(st3), 0);
    chk_val("rstmw_pc_en",       32'(pc3), 1);
    chk_val("rstmw_wait_clr",    32'(wc3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
